// File: rtl/light_timer.sv
// Clock-to-seconds prescaler plus per-light remaining-seconds down-counter for the traffic-light FSM.
// Strobes are combinational from registered state; a new duration loads at the wrap edge once the count is 0.
module light_timer #(
  parameter int LIGHT_STATE_WIDTH = 3,
  parameter int CLK_PER_SEC       = 4,
  parameter int GREEN_SEC         = 3,
  parameter int YELLOW_SEC        = 1,
  parameter int RED_SEC           = 2,
  parameter int CNT_WIDTH         = 8,
  parameter int SEC_WIDTH         = $clog2(CLK_PER_SEC)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
  output logic                         second_cnt_pre_last,
  output logic                         light_cnt_last,
  output logic                         sec_tick,
  output logic [CNT_WIDTH-1:0]         light_cnt
);

  localparam int MAX_GY  = (GREEN_SEC > YELLOW_SEC) ? GREEN_SEC : YELLOW_SEC;
  localparam int MAX_SEC = (MAX_GY > RED_SEC) ? MAX_GY : RED_SEC;
  localparam longint CNT_MAX = (CNT_WIDTH >= 62) ? 64'h3fff_ffff_ffff_ffff
                                                  : ((64'd1 << CNT_WIDTH) - 64'd1);

  if (CLK_PER_SEC < 2) begin : g_err_clk
    $error("light_timer: CLK_PER_SEC must be at least 2");
  end
  if (GREEN_SEC < 1 || YELLOW_SEC < 1 || RED_SEC < 1) begin : g_err_sec
    $error("light_timer: every light duration must be at least 1 second");
  end
  if (longint'(MAX_SEC - 1) > CNT_MAX) begin : g_err_cnt
    $error("light_timer: CNT_WIDTH too small for the longest light duration");
  end
  if (LIGHT_STATE_WIDTH < 3) begin : g_err_sel
    $error("light_timer: LIGHT_STATE_WIDTH must cover green, yellow and red");
  end

  localparam logic [SEC_WIDTH-1:0] SEC_LAST = SEC_WIDTH'(CLK_PER_SEC - 1);
  localparam logic [SEC_WIDTH-1:0] SEC_PRE  = SEC_WIDTH'(CLK_PER_SEC - 2);

  localparam logic [LIGHT_STATE_WIDTH-1:0] SEL_GREEN  = LIGHT_STATE_WIDTH'(1);
  localparam logic [LIGHT_STATE_WIDTH-1:0] SEL_YELLOW = LIGHT_STATE_WIDTH'(2);
  localparam logic [LIGHT_STATE_WIDTH-1:0] SEL_RED    = LIGHT_STATE_WIDTH'(4);

  localparam logic [CNT_WIDTH-1:0] GREEN_LD  = CNT_WIDTH'(GREEN_SEC - 1);
  localparam logic [CNT_WIDTH-1:0] YELLOW_LD = CNT_WIDTH'(YELLOW_SEC - 1);
  localparam logic [CNT_WIDTH-1:0] RED_LD    = CNT_WIDTH'(RED_SEC - 1);

  logic [SEC_WIDTH-1:0] sec_cnt;
  logic [CNT_WIDTH-1:0] load_val;

  assign second_cnt_pre_last = en && (sec_cnt == SEC_PRE);
  assign sec_tick            = en && (sec_cnt == SEC_LAST);
  assign light_cnt_last      = (light_cnt == '0);

  // Idle and multi-hot selects both decode to 0, so the count simply stays parked at 0.
  always_comb begin
    load_val = '0;
    if (light_cnt_init == SEL_GREEN) begin
      load_val = GREEN_LD;
    end else if (light_cnt_init == SEL_YELLOW) begin
      load_val = YELLOW_LD;
    end else if (light_cnt_init == SEL_RED) begin
      load_val = RED_LD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      sec_cnt   <= '0;
      light_cnt <= '0;
    end else begin
      sec_cnt <= (sec_cnt == SEC_LAST) ? '0 : sec_cnt + SEC_WIDTH'(1);
      if (sec_tick) begin
        light_cnt <= light_cnt_last ? load_val : light_cnt - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_light_timer.sv
// Scoreboard bench for light_timer: directed per-cycle expectations plus a closed loop with a small light FSM.
module tb_light_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] init_drv;
  logic [2:0] fsm;
  logic [2:0] light_cnt_init;
  logic       loop_on;
  logic       pre_w, last_w, tick_w;
  logic [7:0] cnt_w;

  typedef struct {
    logic       pre;
    logic       tick;
    logic       last;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  typedef struct {
    logic [2:0] state;
    int         len;
  } run_t;

  exp_t exp_q[$];
  run_t run_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [2:0] init_tab [0:6] = '{3'b011, 3'b110, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100};
  int         cnt_tab  [0:6] = '{0, 0, 0, 2, 1, 0, 1};

  always #5 clk = ~clk;

  assign light_cnt_init = loop_on ? fsm : init_drv;

  light_timer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .light_cnt_init      (light_cnt_init),
    .second_cnt_pre_last (pre_w),
    .light_cnt_last      (last_w),
    .sec_tick            (tick_w),
    .light_cnt           (cnt_w)
  );

  // Partner light FSM: advances on last & pre_last, so the new select is present in the wrap cycle.
  always @(posedge clk) begin
    if (!loop_on) begin
      fsm <= 3'b000;
    end else if (last_w && pre_w) begin
      case (fsm)
        3'b001:  fsm <= 3'b010;
        3'b010:  fsm <= 3'b100;
        default: fsm <= 3'b001;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  // Per-cycle monitor: one expectation is consumed in every cycle the stimulus queued one.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if ({pre_w, tick_w, last_w, cnt_w} === {e.pre, e.tick, e.last, e.cnt}) begin
        n_pass++;
      end else begin
        $display("FAIL %s: actual pre=%b tick=%b last=%b cnt=%0d required pre=%b tick=%b last=%b cnt=%0d",
                 e.tag, pre_w, tick_w, last_w, cnt_w, e.pre, e.tick, e.last, e.cnt);
      end
    end
  end

  int         cyc = 0;
  int         run_len = 0;
  logic [2:0] prev_state = 3'b000;

  // Closed-loop monitor: measures how long the FSM dwells in each light.
  always @(negedge clk) begin
    if (loop_on) begin
      if (fsm !== prev_state) begin
        if (prev_state == 3'b000) begin
          chk("first_green_delay", cyc, 3);
          chk("first_light_is_green", {29'd0, fsm}, 3'b001);
        end else if (run_q.size() > 0) begin
          run_t r;
          r = run_q.pop_front();
          chk("loop_state", {29'd0, prev_state}, {29'd0, r.state});
          chk("loop_len", run_len, r.len);
        end
        prev_state = fsm;
        run_len    = 1;
      end else begin
        run_len++;
      end
      cyc++;
    end
  end

  task automatic step(input logic r, input logic e, input logic [2:0] i,
                      input logic xp, input logic xt, input logic xl, input int xc,
                      input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n    = r;
    en       = e;
    init_drv = i;
    x.pre  = xp;
    x.tick = xt;
    x.last = xl;
    x.cnt  = 8'(xc);
    x.tag  = tag;
    exp_q.push_back(x);
  endtask

  initial begin
    int c;
    rst_n    = 1'b0;
    en       = 1'b1;
    init_drv = 3'b000;
    loop_on  = 1'b0;

    // Reset held with en high
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 0, "reset");

    // Prescaler, idle select
    for (int k = 0; k < 20; k++)
      step(1'b1, 1'b1, 3'b000, (k % 4) == 2, (k % 4) == 3, 1'b1, 0, "prescaler");

    // Green held from a fresh second: 0,0,0,0 then 2,1,0 per second
    for (int j = 0; j < 22; j++) begin
      c = (j < 4) ? 0 : 2 - (((j - 4) / 4) % 3);
      step(1'b1, 1'b1, 3'b001, (j % 4) == 2, (j % 4) == 3, c == 0, c, "green_load");
    end

    // Disable in the pre_last cycle with count 1, then clear, then restart
    step(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1, "disable_gate");
    step(1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 0, "disable_clear");

    // Re-enable; illegal selects, then green, then red requested while counting
    for (int e = 0; e < 25; e++)
      step(1'b1, 1'b1, init_tab[e / 4], (e % 4) == 2, (e % 4) == 3,
           cnt_tab[e / 4] == 0, cnt_tab[e / 4], "select_seq");

    // Reset mid-count: no change until the edge, then restart from zero
    step(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1, "reset_mid_hold");
    step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 0, "reset_mid_clear");
    step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 0, "restart_sec1");
    step(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 0, "restart_sec2");
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 0, "pre_loop_disable");

    // Closed loop: green 12, yellow 4, red 8 cycles, twice
    for (int k = 0; k < 2; k++) begin
      run_q.push_back('{state: 3'b001, len: 12});
      run_q.push_back('{state: 3'b010, len: 4});
      run_q.push_back('{state: 3'b100, len: 8});
    end
    @(posedge clk);
    #1;
    en      = 1'b1;
    loop_on = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    #1;
    chk("loop_runs_outstanding", run_q.size(), 0);
    chk("scoreboard_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/light_timer.md
Name: light_timer

Overview:
- Timing back-end for the traffic-light FSM.
- Consumes the FSM's one-hot `light_cnt_init` request.
- Produces the `light_cnt_last` and `second_cnt_pre_last` strobes that the FSM uses to advance GREEN -> YELLOW -> RED.
- Contains a clock-to-seconds prescaler and a per-light down-counter of remaining seconds. It sits beside the light FSM in the traffic-light top.

Parameters:
- LIGHT_STATE_WIDTH, 3, width of `light_cnt_init`: bit0 = green, bit1 = yellow, bit2 = red.
- CLK_PER_SEC, 4, clock cycles per second; must be >= 2.
- GREEN_SEC, 3, green duration in seconds; must be >= 1.
- YELLOW_SEC, 1, yellow duration in seconds; must be >= 1.
- RED_SEC, 2, red duration in seconds; must be >= 1.
- CNT_WIDTH, 8, width of the seconds counter; must hold max(GREEN_SEC, YELLOW_SEC, RED_SEC) - 1.
- SEC_WIDTH, $clog2(CLK_PER_SEC), width of the prescaler counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  run enable; low holds the block cleared.
- light_cnt_init  input  LIGHT_STATE_WIDTH  one-hot duration select from the FSM; 0 = idle.
- second_cnt_pre_last  output  1  high in the cycle before the last cycle of each second.
- light_cnt_last  output  1  high while the remaining-seconds count is 0.
- sec_tick  output  1  high in the last cycle of each second, i.e. the wrap cycle.
- light_cnt  output  CNT_WIDTH  remaining whole seconds minus one, for display.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `rst_n`. `rst_n` is sampled only at the rising edge and has priority over `en`.
- Reset values: sec_cnt = 0 and light_cnt = 0, so light_cnt_last = 1, second_cnt_pre_last = 0, sec_tick = 0.
- Disabled (en = 0, rst_n = 1): at the next edge sec_cnt and light_cnt clear to 0.
- Prescaler (en = 1):
  - sec_cnt increments every cycle, 0..CLK_PER_SEC-1, and wraps to 0.
  - Outputs are combinational from registered state, zero added latency:
    - second_cnt_pre_last = en & (sec_cnt == CLK_PER_SEC-2).
    - sec_tick = en & (sec_cnt == CLK_PER_SEC-1).
- Seconds counter (updated only on the edge where sec_tick = 1):
  - If light_cnt != 0: decrement.
  - If light_cnt == 0: load duration-1 chosen by light_cnt_init:
    - 001 -> GREEN_SEC-1.
    - 010 -> YELLOW_SEC-1.
    - 100 -> RED_SEC-1.
    - 000 or any multi-hot value -> 0, no load.
  - light_cnt never underflows.
- light_cnt_last = (light_cnt == 0), combinational.
- Loop timing with the FSM:
  - The FSM sees last = light_cnt_last & second_cnt_pre_last and updates light_cnt_init at the following edge, i.e. in the wrap cycle.
  - The timer loads the new duration at the wrap edge.
  - Result: each light lasts exactly DURATION_SEC * CLK_PER_SEC cycles.
  - From idle, the first light starts after at most one second.
- Boundary conditions:
  - light_cnt_init changing while light_cnt != 0 has no effect until the count reaches 0.
  - en falling mid-second: pre_last and sec_tick drop in the same cycle (combinational gating); counters clear at the next edge.
  - rst_n low mid-operation: clears at the next edge regardless of en.
  - When en is restored, counting resumes from sec_cnt = 0, light_cnt = 0.
- Elaboration: a parameter violation (CLK_PER_SEC < 2, any *_SEC < 1, CNT_WIDTH too small) raises an elaboration-time error.

Test Plan:
1. Reset: rst_n = 0 for 2 edges with en = 1 -> sec_cnt = 0, light_cnt = 0, light_cnt_last = 1, second_cnt_pre_last = 0, sec_tick = 0. rst_n low between edges changes nothing until an edge.
2. Prescaler: en = 1, light_cnt_init = 000, 20 cycles -> second_cnt_pre_last high exactly when sec_cnt = 2, sec_tick exactly when sec_cnt = 3 (once per 4 cycles); light_cnt_last stays 1; light_cnt stays 0.
3. Green load: light_cnt_init = 001 held from cycle 0 -> at the first sec_tick edge light_cnt = 2, then 1 and 0 at the next two ticks; light_cnt_last high only in the 4-cycle window with count 0, then reload to 2.
4. Closed loop with the light FSM, defaults -> repeating light pattern: green 12 cycles, yellow 4 cycles, red 8 cycles. The first green starts within 4 cycles of en rising.
5. Disable mid-count: en = 0 while light_cnt = 1, sec_cnt = 2 -> pre_last = 0 in the same cycle; next edge sec_cnt = 0, light_cnt = 0, last = 1. Re-enable -> pre_last first seen 2 cycles later.
6. Illegal select: light_cnt_init = 011 or 110 at the reload tick -> light_cnt stays 0 and light_cnt_last stays 1. Changing init from 001 to 100 while light_cnt = 2 -> no reload until the count reaches 0, then loads 1.
